// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// mux selects, ALU operations and immediate formats.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [2:0] SE_I    = 3'b000;
    localparam logic [2:0] SE_S    = 3'b001;
    localparam logic [2:0] SE_B    = 3'b011;
    localparam logic [2:0] SE_J    = 3'b100;
    localparam logic [2:0] SE_NONE = 3'b111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Moore control word for each state; unlisted fields stay zero.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_update  = 1'b1;
                c.result_src = RES_ALU;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALU_OP_ADD;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_OP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB:    c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_RS2;
                c.alu_op    = ALU_OP_SUB;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] type_se_of(input logic [6:0] op);
        case (op)
            OP_I, OP_LW: return SE_I;
            OP_SW:       return SE_S;
            OP_BEQ:      return SE_B;
            OP_JAL:      return SE_J;
            default:     return SE_NONE;
        endcase
    endfunction

    function automatic logic op_legal(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control unit (master) and the datapath (slave).
// Every control is a level, valid for the whole cycle; there is no valid/ready handshake.
interface multicycle_control_if;

    logic [6:0]          op;
    logic [2:0]          funct3;
    logic                funct7b5;
    logic                zero;
    logic                pc_write;
    logic                adr_src;
    logic                mem_write;
    logic                ir_write;
    logic                reg_write;
    logic [1:0]          result_src;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic [2:0]          alu_control;
    logic [2:0]          type_SE;
    logic                illegal;
    riscv_pkg::state_t   state;

    modport master (
        input  op, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, alu_control, type_SE,
        output illegal, state
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, alu_control, type_SE,
        input  illegal, state
    );

endinterface

// File: rtl/alu_decoder.sv
// Maps the coarse ALU operation plus funct fields onto the ALU control code.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op_b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) can subtract; addi ignores instr[30].
                    3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default:    alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: one state per clock, registered Moore control word,
// with the branch-taken term of pc_write as the only combinational dependency on zero.
module multicycle_control
    import riscv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_if.master   bus
);

    state_t state_d, state_q;
    ctrl_t  ctrl_d, ctrl_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
        // Registering the decode of the next state keeps ctrl_q aligned with state_q.
        ctrl_d = state_ctrl(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Enables are gated by rst_n so that FETCH selects can be held during reset
    // while no load or write reaches the datapath.
    assign bus.pc_write   = rst_n & (ctrl_q.pc_update | (ctrl_q.branch & bus.zero));
    assign bus.ir_write   = rst_n & ctrl_q.ir_write;
    assign bus.mem_write  = rst_n & ctrl_q.mem_write;
    assign bus.reg_write  = rst_n & ctrl_q.reg_write;
    assign bus.adr_src    = ctrl_q.adr_src;
    assign bus.result_src = ctrl_q.result_src;
    assign bus.alu_src_a  = ctrl_q.alu_src_a;
    assign bus.alu_src_b  = ctrl_q.alu_src_b;
    assign bus.type_SE    = type_se_of(bus.op);
    assign bus.illegal    = rst_n & (state_q == S_DECODE) & ~op_legal(bus.op);
    assign bus.state      = state_q;

    alu_decoder u_alu_decoder (
        .alu_op      (ctrl_q.alu_op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .op_b5       (bus.op[5]),
        .alu_control (bus.alu_control)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle vector bench for multicycle_control plus reset corner sequences.
module tb_multicycle_control;
    import riscv_pkg::*;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        state_t      st;
        logic [18:0] exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    vec_t vecs[$];

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a,
    //  alu_src_b, alu_control, type_SE, illegal}
    function automatic logic [18:0] outs();
        return {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control,
                bus.type_SE, bus.illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.zero     = z;
    endtask

    task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input state_t st, input logic [18:0] exp);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.st = st; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(OP_LW, 3'b010, 1'b0, 1'b1);

        // lw
        add(OP_LW, 3'b010, 0, 1, S_FETCH,    19'b1_0_0_1_0_10_00_10_000_000_0);
        add(OP_LW, 3'b010, 0, 1, S_DECODE,   19'b0_0_0_0_0_00_01_01_000_000_0);
        add(OP_LW, 3'b010, 0, 1, S_MEMADR,   19'b0_0_0_0_0_00_10_01_000_000_0);
        add(OP_LW, 3'b010, 0, 1, S_MEMREAD,  19'b0_1_0_0_0_00_00_00_000_000_0);
        add(OP_LW, 3'b010, 0, 1, S_MEMWB,    19'b0_0_0_0_1_01_00_00_000_000_0);
        // sw
        add(OP_SW, 3'b010, 0, 1, S_FETCH,    19'b1_0_0_1_0_10_00_10_000_001_0);
        add(OP_SW, 3'b010, 0, 1, S_DECODE,   19'b0_0_0_0_0_00_01_01_000_001_0);
        add(OP_SW, 3'b010, 0, 1, S_MEMADR,   19'b0_0_0_0_0_00_10_01_000_001_0);
        add(OP_SW, 3'b010, 0, 1, S_MEMWRITE, 19'b0_1_1_0_0_00_00_00_000_001_0);
        // R sub
        add(OP_R, 3'b000, 1, 1, S_FETCH,     19'b1_0_0_1_0_10_00_10_000_111_0);
        add(OP_R, 3'b000, 1, 1, S_DECODE,    19'b0_0_0_0_0_00_01_01_000_111_0);
        add(OP_R, 3'b000, 1, 1, S_EXECUTER,  19'b0_0_0_0_0_00_10_00_001_111_0);
        add(OP_R, 3'b000, 1, 1, S_ALUWB,     19'b0_0_0_0_1_00_00_00_000_111_0);
        // R and
        add(OP_R, 3'b111, 0, 1, S_FETCH,     19'b1_0_0_1_0_10_00_10_000_111_0);
        add(OP_R, 3'b111, 0, 1, S_DECODE,    19'b0_0_0_0_0_00_01_01_000_111_0);
        add(OP_R, 3'b111, 0, 1, S_EXECUTER,  19'b0_0_0_0_0_00_10_00_010_111_0);
        add(OP_R, 3'b111, 0, 1, S_ALUWB,     19'b0_0_0_0_1_00_00_00_000_111_0);
        // R slt
        add(OP_R, 3'b010, 0, 1, S_FETCH,     19'b1_0_0_1_0_10_00_10_000_111_0);
        add(OP_R, 3'b010, 0, 1, S_DECODE,    19'b0_0_0_0_0_00_01_01_000_111_0);
        add(OP_R, 3'b010, 0, 1, S_EXECUTER,  19'b0_0_0_0_0_00_10_00_101_111_0);
        add(OP_R, 3'b010, 0, 1, S_ALUWB,     19'b0_0_0_0_1_00_00_00_000_111_0);
        // R or
        add(OP_R, 3'b110, 0, 1, S_FETCH,     19'b1_0_0_1_0_10_00_10_000_111_0);
        add(OP_R, 3'b110, 0, 1, S_DECODE,    19'b0_0_0_0_0_00_01_01_000_111_0);
        add(OP_R, 3'b110, 0, 1, S_EXECUTER,  19'b0_0_0_0_0_00_10_00_011_111_0);
        add(OP_R, 3'b110, 0, 1, S_ALUWB,     19'b0_0_0_0_1_00_00_00_000_111_0);
        // addi with instr[30] set must still add
        add(OP_I, 3'b000, 1, 1, S_FETCH,     19'b1_0_0_1_0_10_00_10_000_000_0);
        add(OP_I, 3'b000, 1, 1, S_DECODE,    19'b0_0_0_0_0_00_01_01_000_000_0);
        add(OP_I, 3'b000, 1, 1, S_EXECUTEI,  19'b0_0_0_0_0_00_10_01_000_000_0);
        add(OP_I, 3'b000, 1, 1, S_ALUWB,     19'b0_0_0_0_1_00_00_00_000_000_0);
        // andi
        add(OP_I, 3'b111, 0, 1, S_FETCH,     19'b1_0_0_1_0_10_00_10_000_000_0);
        add(OP_I, 3'b111, 0, 1, S_DECODE,    19'b0_0_0_0_0_00_01_01_000_000_0);
        add(OP_I, 3'b111, 0, 1, S_EXECUTEI,  19'b0_0_0_0_0_00_10_01_010_000_0);
        add(OP_I, 3'b111, 0, 1, S_ALUWB,     19'b0_0_0_0_1_00_00_00_000_000_0);
        // beq taken
        add(OP_BEQ, 3'b000, 0, 1, S_FETCH,   19'b1_0_0_1_0_10_00_10_000_011_0);
        add(OP_BEQ, 3'b000, 0, 1, S_DECODE,  19'b0_0_0_0_0_00_01_01_000_011_0);
        add(OP_BEQ, 3'b000, 0, 1, S_BEQ,     19'b1_0_0_0_0_00_10_00_001_011_0);
        // beq not taken
        add(OP_BEQ, 3'b000, 0, 0, S_FETCH,   19'b1_0_0_1_0_10_00_10_000_011_0);
        add(OP_BEQ, 3'b000, 0, 0, S_DECODE,  19'b0_0_0_0_0_00_01_01_000_011_0);
        add(OP_BEQ, 3'b000, 0, 0, S_BEQ,     19'b0_0_0_0_0_00_10_00_001_011_0);
        // jal
        add(OP_JAL, 3'b101, 1, 1, S_FETCH,   19'b1_0_0_1_0_10_00_10_000_100_0);
        add(OP_JAL, 3'b101, 1, 1, S_DECODE,  19'b0_0_0_0_0_00_01_01_000_100_0);
        add(OP_JAL, 3'b101, 1, 1, S_JAL,     19'b1_0_0_0_0_00_01_10_000_100_0);
        add(OP_JAL, 3'b101, 1, 1, S_ALUWB,   19'b0_0_0_0_1_00_00_00_000_100_0);
        // illegal opcode
        add(7'h7f, 3'b000, 0, 1, S_FETCH,    19'b1_0_0_1_0_10_00_10_000_111_0);
        add(7'h7f, 3'b000, 0, 1, S_DECODE,   19'b0_0_0_0_0_00_01_01_000_111_1);
        add(OP_LW, 3'b010, 0, 1, S_FETCH,    19'b1_0_0_1_0_10_00_10_000_000_0);

        // reset held for 3 cycles: FETCH selects, no enables
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("reset_outs[%0d]", i), 32'(outs()),
                32'(19'b0_0_0_0_0_10_00_10_000_000_0));
            chk($sformatf("reset_state[%0d]", i), 32'(bus.state), 32'(S_FETCH));
        end
        #2 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
            #1;
            chk($sformatf("vec_outs[%0d]", i), 32'(outs()), 32'(vecs[i].exp));
            chk($sformatf("vec_state[%0d]", i), 32'(bus.state), 32'(vecs[i].st));
            step();
        end

        // sw interrupted by reset while in MEMWRITE (FSM entered DECODE at the last edge)
        drive(OP_SW, 3'b010, 1'b0, 1'b1);
        #1;
        chk("abort_decode", 32'(bus.state), 32'(S_DECODE));
        step();
        chk("abort_memadr", 32'(bus.state), 32'(S_MEMADR));
        step();
        chk("abort_memwrite_state", 32'(bus.state), 32'(S_MEMWRITE));
        chk("abort_mem_write_hi", 32'(bus.mem_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_write_lo", 32'(bus.mem_write), 32'd0);
        chk("abort_state", 32'(bus.state), 32'(S_FETCH));
        chk("abort_outs", 32'(outs()), 32'(19'b0_0_0_0_0_10_00_10_000_001_0));
        step();
        chk("abort_hold_state", 32'(bus.state), 32'(S_FETCH));
        chk("abort_hold_ir_write", 32'(bus.ir_write), 32'd0);
        #2 rst_n = 1'b1;
        drive(OP_R, 3'b111, 1'b0, 1'b0);
        #1;
        chk("release_fetch", 32'(outs()), 32'(19'b1_0_0_1_0_10_00_10_000_111_0));
        step();
        chk("release_first_edge", 32'(bus.state), 32'(S_DECODE));
        step();
        chk("release_exec_alu", 32'(bus.alu_control), 32'(ALU_AND));
        chk("release_exec_state", 32'(bus.state), 32'(S_EXECUTER));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control unit that sequences the multicycle RV32I datapath (PC, instruction/data memory port, register file, immediate sign-extension unit, ALU) one state per clock. It decodes the instruction register's opcode/funct fields and drives every multiplexer select, write enable, ALU operation and the sign-extension type code `type_SE` for that cycle. It sits beside the datapath top level and replaces the single-cycle combinational decoder.

## Interface
- Parameters: none. Opcode, state and ALU encodings come from the shared package.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7b5` in 1: `instr[30]`.
- `zero` in 1: ALU zero flag.
- `pc_write` out 1: PC load enable.
- `adr_src` out 1: memory address select (0 = PC, 1 = ALUOut).
- `mem_write` out 1: data memory write enable.
- `ir_write` out 1: instruction register and oldPC load enable.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result select (00 = ALUOut, 01 = read data, 10 = ALU result).
- `alu_src_a` out 2: ALU A select (00 = PC, 01 = oldPC, 10 = rs1).
- `alu_src_b` out 2: ALU B select (00 = rs2, 01 = immExt, 10 = constant 4).
- `alu_control` out 3: ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt).
- `type_SE` out 3: immediate format code for the sign-extension unit.
- `illegal` out 1: one-cycle pulse when an unsupported opcode is detected.

## Operation
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- State transitions:
  - FETCH → DECODE.
  - DECODE → by opcode: lw/sw → MEMADR; R → EXECUTER; I → EXECUTEI; beq → BEQ; jal → JAL; any other opcode → FETCH with `illegal` = 1.
  - MEMADR → MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD → MEMWB.
  - EXECUTER and EXECUTEI → ALUWB.
  - JAL → ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ → FETCH.
- Moore outputs per state. Any output not listed is 0.
  - FETCH: `adr_src` 0, `ir_write` 1, `alu_src_a` 00, `alu_src_b` 10, add, `result_src` 10, PC update.
  - DECODE: `alu_src_a` 01, `alu_src_b` 01, add (computes the branch target).
  - MEMADR: `alu_src_a` 10, `alu_src_b` 01, add.
  - MEMREAD: `result_src` 00, `adr_src` 1.
  - MEMWB: `result_src` 01, `reg_write` 1.
  - MEMWRITE: `result_src` 00, `adr_src` 1, `mem_write` 1.
  - EXECUTER: `alu_src_a` 10, `alu_src_b` 00, funct-decoded operation.
  - EXECUTEI: `alu_src_a` 10, `alu_src_b` 01, funct-decoded operation.
  - ALUWB: `result_src` 00, `reg_write` 1.
  - BEQ: `alu_src_a` 10, `alu_src_b` 00, sub, `result_src` 00, branch.
  - JAL: `alu_src_a` 01, `alu_src_b` 10, add, `result_src` 00, PC update.
- `pc_write` = PC update | (branch & `zero`). This is the only Mealy term.
- ALU operation code `alu_op`:
  - 00 → add.
  - 01 → sub.
  - 10 → decode `funct3`: 000 → sub if `op[5]` & `funct7b5`, else add; 010 → slt; 110 → or; 111 → and; anything else → add.
- `type_SE` is combinational from `op`:
  - I-ALU and lw → 000.
  - sw → 001.
  - beq → 011.
  - jal → 100.
  - R-type and unknown opcodes → 111 (sign-extension unit outputs zero).

## Timing
- Reset:
  - While `rst_n` is low, state = FETCH.
  - `pc_write`, `ir_write`, `mem_write`, `reg_write` and `illegal` are forced to 0 asynchronously.
  - Mux selects hold their FETCH values.
- The first FETCH executes on the first rising edge after `rst_n` deasserts.
- Cycles per instruction, FETCH inclusive: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- Inputs are sampled at DECODE and later. `op` is stable from the cycle after FETCH until the next FETCH, because `ir_write` is asserted only in FETCH.
- Reset asserted mid-instruction aborts it immediately. No partial write occurs after `rst_n` falls.
- In BEQ, `zero` comes from the same-cycle subtraction. A taken branch loads the target from ALUOut (computed in DECODE) at the BEQ edge.
- An illegal opcode costs 2 cycles (FETCH, DECODE) and commits no write. `illegal` is high only during that DECODE cycle.

## Structure
- Package `riscv_pkg` holds:
  - opcode localparams;
  - the state enum;
  - `alu_control`, `alu_op`, `type_SE`, `result_src` and source-select encodings.
- Sub-module `alu_decoder`: combinational, (`alu_op`, `funct3`, `funct7b5`, `op[5]`) → `alu_control`.
- The main module holds the state register, next-state logic and the output decoder.

## Test plan
- Reset held 3 cycles, then released with `op` = lw (0000011) → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB. `reg_write` = 1 only in cycle 5, with `result_src` = 01 and `type_SE` = 000.
- sw (0100011) → `mem_write` = 1 only in cycle 4, with `adr_src` = 1 and `type_SE` = 001. Back in FETCH at cycle 5.
- R-type with `funct3` 000 and `funct7b5` 1 → EXECUTER `alu_control` = 001. With `funct3` 111 → 010. With `funct3` 010 → 101. `reg_write` in ALUWB only.
- beq with `zero` = 1 → `pc_write` = 1 in BEQ (cycle 3). With `zero` = 0 → `pc_write` = 0. `type_SE` = 011 in both cases.
- jal (1101111) → `pc_write` = 1 in FETCH and JAL, `reg_write` = 1 in ALUWB, `type_SE` = 100.
- Opcode 1111111 → `illegal` pulses 1 cycle in DECODE and the FSM returns to FETCH. Separately, `rst_n` dropped during MEMWRITE → `mem_write` falls to 0 at once and the state is FETCH.
